mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter that gives a read-only fetch requester and
// a load/store data requester access to one shared memory port.
//
// Ports
//   clk, reset                  clock, asynchronous active-high reset
//   f_en, f_addr                fetch read request
//   f_do, f_ack                 fetch read data (held) and one-cycle done pulse
//   d_en, d_we, d_addr, d_di    data request (d_we=1 store, 0 load)
//   d_do, d_ack                 load data (held) and one-cycle done pulse
//   err                         high with f_ack/d_ack when the access timed out
//   mem_en, mem_we, mem_addr,   registered shared memory request
//   mem_di
//   mem_do, mem_ack             memory read data, valid while mem_ack=1
//   busy                        high whenever a transaction is in progress
//
// One transaction at a time: IDLE grants, BUSY waits for mem_ack (bounded by
// TIMEOUT cycles), RELEASE is a one-cycle gap before the next grant.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  f_en,
  input  logic [ADDR_WIDTH-1:0] f_addr,
  output logic [DATA_WIDTH-1:0] f_do,
  output logic                  f_ack,
  input  logic                  d_en,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_di,
  output logic [DATA_WIDTH-1:0] d_do,
  output logic                  d_ack,
  output logic                  err,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_di,
  input  logic [DATA_WIDTH-1:0] mem_do,
  input  logic                  mem_ack,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RELEASE = 2'd2} state_t;

  // The counter value seen on the edge that would make it equal TIMEOUT.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t                state_q, state_d;
  logic                  grant_q, grant_d;   // 0 = fetch, 1 = data
  logic                  last_q, last_d;     // requester served most recently
  logic [7:0]            cnt_q, cnt_d;
  logic                  mem_en_q, mem_en_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_di_q, mem_di_d;
  logic [DATA_WIDTH-1:0] f_do_q, f_do_d;
  logic [DATA_WIDTH-1:0] d_do_q, d_do_d;
  logic                  f_ack_q, f_ack_d;
  logic                  d_ack_q, d_ack_d;
  logic                  err_q, err_d;
  logic                  pick;
  logic                  timeout_hit;

  assign timeout_hit = (cnt_q == CNT_LAST);

  // State register and all datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= 1'b0;
      last_q     <= 1'b1;  // fetch wins the first tie
      cnt_q      <= '0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_di_q   <= '0;
      f_do_q     <= '0;
      d_do_q     <= '0;
      f_ack_q    <= 1'b0;
      d_ack_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_di_q   <= mem_di_d;
      f_do_q     <= f_do_d;
      d_do_q     <= d_do_d;
      f_ack_q    <= f_ack_d;
      d_ack_q    <= d_ack_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (f_en || d_en) state_d = BUSY;
      BUSY:    if (mem_ack || timeout_hit) state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath / output next values.
  always_comb begin
    grant_d    = grant_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    mem_en_d   = mem_en_q;
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_di_d   = mem_di_q;
    f_do_d     = f_do_q;
    d_do_d     = d_do_q;
    f_ack_d    = 1'b0;
    d_ack_d    = 1'b0;
    err_d      = 1'b0;
    // On a tie serve whoever was not served last; otherwise the sole requester.
    pick       = (f_en && d_en) ? ~last_q : d_en;
    case (state_q)
      IDLE: begin
        if (f_en || d_en) begin
          grant_d  = pick;
          cnt_d    = '0;
          mem_en_d = 1'b1;
          if (pick) begin
            mem_we_d   = d_we;
            mem_addr_d = d_addr;
            mem_di_d   = d_di;
          end else begin
            mem_we_d   = 1'b0;
            mem_addr_d = f_addr;
            mem_di_d   = '0;
          end
        end
      end
      BUSY: begin
        // mem_ack takes priority so an ack on the last allowed cycle is a
        // normal completion.
        if (mem_ack) begin
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          last_d   = grant_q;
          if (grant_q) begin
            d_ack_d = 1'b1;
            if (!mem_we_q) d_do_d = mem_do;
          end else begin
            f_ack_d = 1'b1;
            f_do_d  = mem_do;
          end
        end else if (timeout_hit) begin
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          last_d   = grant_q;
          err_d    = 1'b1;
          if (grant_q) begin
            d_ack_d = 1'b1;
            d_do_d  = '0;
          end else begin
            f_ack_d = 1'b1;
            f_do_d  = '0;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  assign f_do     = f_do_q;
  assign f_ack    = f_ack_q;
  assign d_do     = d_do_q;
  assign d_ack    = d_ack_q;
  assign err      = err_q;
  assign mem_en   = mem_en_q;
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_di   = mem_di_q;
  assign busy     = (state_q != IDLE);

endmodule
